// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction arbiter: state encoding, frame
// layout and default timing parameters.
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_RUN     = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_GAP     = 3'd4
   } state_e;

   localparam int RW_BIT   = 15;
   localparam int ADDR_MSB = 14;
   localparam int ADDR_LSB = 8;
   localparam int DATA_MSB = 7;
   localparam int DATA_LSB = 0;

   localparam int DEF_CLK_DIV        = 25;
   localparam int DEF_GAP_CYCLES     = 8;
   localparam int DEF_TIMEOUT_PULSES = 24;

   // Reads carry an all-zero data field so the engine shifts out a clean byte.
   function automatic logic [15:0] packFrame(input logic       rw,
                                             input logic [6:0] addr,
                                             input logic [7:0] wdata);
      logic [15:0] frame;
      frame                    = '0;
      frame[RW_BIT]            = rw;
      frame[ADDR_MSB:ADDR_LSB] = addr;
      frame[DATA_MSB:DATA_LSB] = rw ? 8'h00 : wdata;
      return frame;
   endfunction

endpackage

// File: rtl/spi_pulse_gen.sv
// SCLK pulse generator: one-cycle pulse every CLK_DIV clocks while enabled,
// divider forced back to zero whenever clear is high.
module spi_pulse_gen import spi_pkg::*; #(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic pulse
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [7:0] divCnt_q;
   logic [7:0] divCnt_d;

   always_comb begin
      divCnt_d = divCnt_q;
      if (clear) begin
         divCnt_d = '0;
      end else if (enable) begin
         divCnt_d = (divCnt_q == DIV_LAST) ? 8'd0 : divCnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         divCnt_q <= '0;
      end else begin
         divCnt_q <= divCnt_d;
      end
   end

   assign pulse = enable & ~clear & (divCnt_q == DIV_LAST);

endmodule

// File: rtl/spi_txn_arbiter.sv
// Two-requester round-robin arbiter that frames register transactions for a
// shared SPI shift engine and reports completion, read data and timeouts.
module spi_txn_arbiter import spi_pkg::*; #(
   parameter int CLK_DIV        = DEF_CLK_DIV,
   parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int TIMEOUT_PULSES = DEF_TIMEOUT_PULSES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        rw0,
   input  logic        rw1,
   input  logic [6:0]  addr0,
   input  logic [6:0]  addr1,
   input  logic [7:0]  wdata0,
   input  logic [7:0]  wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic [7:0]  rdata,
   output logic        err,
   output logic        busy,
   output logic [15:0] spi_tx_data,
   output logic        spi_transmit,
   output logic        spi_sclk_pulse,
   output logic        spi_write,
   output logic        spi_read,
   input  logic        spi_tx_done,
   input  logic [7:0]  spi_rx_data
);

   localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);
   localparam logic [4:0]  TIMEOUT_IDX = 5'(TIMEOUT_PULSES);

   state_e      state_q, state_d;
   logic        grantId_q, grantId_d;
   logic        lastServed_q, lastServed_d;
   logic        rw_q, rw_d;
   logic [6:0]  addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [4:0]  pulseIdx_q, pulseIdx_d;
   logic [15:0] gapCnt_q, gapCnt_d;
   logic        timeout_q, timeout_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        grantPick;
   logic        inRun;
   logic        pulse;

   assign inRun = (state_q == ST_RUN);

   spi_pulse_gen #(.CLK_DIV(CLK_DIV)) u_pulseGen (
      .clk    (clk),
      .reset  (reset),
      .enable (inRun),
      .clear  (~inRun),
      .pulse  (pulse)
   );

   always_comb begin
      state_d      = state_q;
      grantId_d    = grantId_q;
      lastServed_d = lastServed_q;
      rw_d         = rw_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      pulseIdx_d   = pulseIdx_q;
      gapCnt_d     = gapCnt_q;
      timeout_d    = timeout_q;
      rdata_d      = rdata_q;
      grantPick    = (req0 & req1) ? ~lastServed_q : req1;

      case (state_q)
         ST_IDLE: begin
            pulseIdx_d = '0;
            if (req0 | req1) begin
               grantId_d    = grantPick;
               lastServed_d = grantPick;
               rw_d         = grantPick ? rw1 : rw0;
               addr_d       = grantPick ? addr1 : addr0;
               wdata_d      = grantPick ? wdata1 : wdata0;
               state_d      = ST_LOAD;
            end
         end
         ST_LOAD: begin
            pulseIdx_d = '0;
            timeout_d  = 1'b0;
            state_d    = ST_RUN;
         end
         ST_RUN: begin
            if (pulse) begin
               pulseIdx_d = pulseIdx_q + 5'd1;
            end
            // A real completion wins over a timeout detected in the same cycle.
            if (spi_tx_done) begin
               timeout_d = 1'b0;
               state_d   = ST_CAPTURE;
               if (rw_q) begin
                  rdata_d = spi_rx_data;
               end
            end else if (pulseIdx_q == TIMEOUT_IDX) begin
               timeout_d = 1'b1;
               state_d   = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            gapCnt_d = '0;
            state_d  = ST_GAP;
         end
         ST_GAP: begin
            if (gapCnt_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gapCnt_d = gapCnt_q + 16'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         grantId_q    <= 1'b0;
         lastServed_q <= 1'b1;
         rw_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         pulseIdx_q   <= '0;
         gapCnt_q     <= '0;
         timeout_q    <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         grantId_q    <= grantId_d;
         lastServed_q <= lastServed_d;
         rw_q         <= rw_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         pulseIdx_q   <= pulseIdx_d;
         gapCnt_q     <= gapCnt_d;
         timeout_q    <= timeout_d;
         rdata_q      <= rdata_d;
      end
   end

   assign ack0           = (state_q == ST_CAPTURE) & ~grantId_q;
   assign ack1           = (state_q == ST_CAPTURE) & grantId_q;
   assign err            = (state_q == ST_CAPTURE) & timeout_q;
   assign rdata          = rdata_q;
   assign busy           = (state_q != ST_IDLE);
   assign spi_tx_data    = packFrame(rw_q, addr_q, wdata_q);
   assign spi_transmit   = ~inRun;
   assign spi_sclk_pulse = pulse;
   // Shift-out covers indices 1..15; shift-in only the data byte, 8..15.
   assign spi_write      = pulse & (pulseIdx_q != 5'd0) & ~pulseIdx_q[4];
   assign spi_read       = pulse & rw_q & (pulseIdx_q[4:3] == 2'b01);

endmodule

// File: doc/spi_txn_arbiter.md
SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

Interface
REQ-001 Parameter CLK_DIV, default 25: system clocks per SCLK pulse period, legal range 2..255.
REQ-002 Parameter GAP_CYCLES, default 8: minimum idle clocks, with spi_transmit high, between frames.
REQ-003 Parameter TIMEOUT_PULSES, default 24: SCLK pulses allowed in RUN before abort.
REQ-004 Port clk  in  1  single system clock; all logic on its rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Ports req0, req1  in  1 each  request level; held high until the matching ack.
REQ-007 Ports rw0, rw1  in  1 each  1=read, 0=write.
REQ-008 Ports addr0, addr1  in  7 each  register address.
REQ-009 Ports wdata0, wdata1  in  8 each  write data; ignored for reads.
REQ-010 Ports ack0, ack1  out  1 each  one-cycle completion pulse.
REQ-011 Port rdata  out  8  read result; valid in the ack cycle, held until the next ack.
REQ-012 Port err  out  1  high in the ack cycle if the transaction timed out.
REQ-013 Port busy  out  1  high in every state except IDLE.
REQ-014 Port spi_tx_data  out  16  frame {rw, addr[6:0], wdata}; wdata field is 0 for reads.
REQ-015 Port spi_transmit  out  1  high = engine held idle/cleared; low = frame runs.
REQ-016 Port spi_sclk_pulse  out  1  one-cycle pulse every CLK_DIV clocks, only in RUN.
REQ-017 Port spi_write  out  1  shift-out strobe.
REQ-018 Port spi_read  out  1  shift-in strobe.
REQ-019 Ports spi_tx_done (1) and spi_rx_data (8)  in  engine completion flag and received byte.

Function
REQ-020 States are IDLE, LOAD, RUN, CAPTURE, and GAP.
REQ-021 IDLE: if any req is high, grant one, latch its rw/addr/wdata and grant_id, then go to LOAD.
REQ-022 Arbitration is round-robin: when both requests are high, grant the one not served last; the first grant after reset prefers req0.
REQ-023 LOAD: spi_tx_data is driven from the latched fields while spi_transmit is still high; next state is RUN.
REQ-024 RUN: spi_transmit is low; the divider starts at 0, and the first pulse occurs CLK_DIV clocks after RUN entry.
REQ-025 A 5-bit pulse index counts pulses within the frame and starts at 0.
REQ-026 spi_write equals spi_sclk_pulse for pulse indices 1..15, for both read and write transactions.
REQ-027 spi_read equals spi_sclk_pulse for pulse indices 8..15, for reads only; it is 0 for writes.
REQ-028 RUN exits to CAPTURE on the first cycle spi_tx_done is high.
REQ-029 RUN also exits to CAPTURE with a timeout flag when the pulse index reaches TIMEOUT_PULSES.
REQ-030 CAPTURE, which lasts one cycle:
- spi_transmit goes high;
- ack of grant_id pulses;
- rdata loads spi_rx_data for reads and is unchanged for writes;
- err equals the timeout flag.
REQ-031 GAP: spi_transmit stays high for GAP_CYCLES clocks, then the state returns to IDLE.
REQ-032 A request still high when GAP ends is eligible in IDLE; the minimum request-to-request period is GAP_CYCLES+2 clocks plus the frame time.
REQ-033 Dropping a req mid-transaction does not abort the transaction; its ack still pulses.
REQ-034 spi_tx_done arriving in any state other than RUN is ignored.
REQ-035 Latency: a write with no contention runs from req to ack in 2 + 17·CLK_DIV clocks (tx_done after the 17th pulse).

Reset
REQ-036 While reset is high, outputs take these values:
- spi_transmit=1;
- spi_sclk_pulse, spi_read, spi_write = 0;
- ack0, ack1, err, busy = 0;
- rdata and spi_tx_data = 0;
- state=IDLE, counters=0, last-served=req1.
REQ-037 Reset asserted mid-frame takes effect on the next edge, with no ack for the aborted transaction.

Structure
REQ-038 The shared package spi_pkg holds:
- the state encoding;
- the frame field positions (RW_BIT=15, ADDR 14:8, DATA 7:0);
- the default CLK_DIV, GAP_CYCLES and TIMEOUT_PULSES.
REQ-039 The pulse generator is one sub-module, spi_pulse_gen (inputs enable and clear; output pulse), cleared whenever the block is not in RUN.

Verification
REQ-040 Write, CLK_DIV=4, req0 with addr=0x2D and wdata=0x08 -> spi_tx_data=0x2D08, 15 spi_write strobes, 0 spi_read, ack0 and err=0.
REQ-041 Read from req1 with addr=0x0F, model returns 0x33 -> spi_tx_data=0x8F00, 8 spi_read strobes at indices 8..15, ack1 with rdata=0x33.
REQ-042 req0 and req1 high together, both held -> grant order req0, req1, req0, with at least GAP_CYCLES between frames.
REQ-043 Model never asserts spi_tx_done, TIMEOUT_PULSES=24 -> ack with err=1 after the 24th pulse, spi_transmit high, rdata unchanged.
REQ-044 Reset at pulse index 5 of a read -> next cycle spi_transmit=1, busy=0, no ack; a subsequent request completes normally.
REQ-045 Spurious spi_tx_done in IDLE and in GAP -> no ack and no state change.
